// File: rtl/am_demod_sched.sv
// ---------------------------------------------------------------------------
// am_demod_sched
//
// Sequencing controller for the AM envelope demodulation path.
//   * Divides clk into a sample strobe (every div_ratio+1 clocks, ratio
//     latched at start).
//   * Half-wave rectifies the signed 8-bit DDS sample and offers it to the
//     FIR low-pass over a valid/ready handshake (one-deep holding register).
//   * Drops DISCARD FIR output beats for filter settling, then tracks the
//     signed max/min of the next WIN_LEN beats and pulses done.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle run request, ignored unless idle
//   div_ratio         strobe period minus one, latched on accepted start
//   sample_in         signed AM sample from the DDS
//   fir_in_tvalid/tready/tdata   rectified sample stream to the FIR
//   fir_out_tvalid/tdata         signed FIR output stream
//   busy              high from the clock after start until done
//   done              one-cycle pulse when the window completes
//   env_max/env_min   signed window extremes, stable from done until next run
//   overrun           sticky: a strobe found the previous sample unaccepted
// ---------------------------------------------------------------------------
module am_demod_sched #(
    parameter int DIV_W   = 8,
    parameter int DISCARD = 64,
    parameter int WIN_LEN = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [7:0]       sample_in,
    output logic             fir_in_tvalid,
    input  logic             fir_in_tready,
    output logic [7:0]       fir_in_tdata,
    input  logic             fir_out_tvalid,
    input  logic [31:0]      fir_out_tdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      env_max,
    output logic [31:0]      env_min,
    output logic             overrun
);

    // Counters only need to reach DISCARD-1 and WIN_LEN-1.
    localparam int SET_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_lat;
    logic [DIV_W-1:0] div_cnt;
    logic [SET_W-1:0] set_cnt;
    logic [WIN_W-1:0] win_cnt;

    logic running;
    logic strobe;
    logic accept;
    logic load_ok;
    logic new_max;
    logic new_min;

    // NOTE: every signal is assigned on every pass through always_comb, so no
    // latch can be inferred; add a default first if a branch is ever added.
    always_comb begin
        running = (state == SETTLE) || (state == MEASURE);
        strobe  = running && (div_cnt == div_lat);
        accept  = fir_in_tvalid && fir_in_tready;
        // The holding register is free if empty or being emptied this edge.
        load_ok = !fir_in_tvalid || fir_in_tready;
        new_max = $signed(fir_out_tdata) > $signed(env_max);
        new_min = $signed(fir_out_tdata) < $signed(env_min);
    end

    // Sample stream to the FIR. Runs in every state so a sample left pending
    // at the end of a run still drains after done.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fir_in_tvalid <= 1'b0;
            fir_in_tdata  <= 8'd0;
        end else if (strobe && load_ok) begin
            fir_in_tvalid <= 1'b1;
            fir_in_tdata  <= sample_in[7] ? 8'd0 : sample_in;
        end else if (accept) begin
            fir_in_tvalid <= 1'b0;
        end
    end

    // Run sequencing, divider, window statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_lat <= '0;
            div_cnt <= '0;
            set_cnt <= '0;
            win_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            env_max <= 32'd0;
            env_min <= 32'd0;
            overrun <= 1'b0;
        end else begin
            done <= 1'b0;

            if (running) begin
                div_cnt <= (div_cnt == div_lat) ? '0 : div_cnt + 1'b1;
            end

            // A strobe that cannot be loaded is dropped; the pending sample
            // stays untouched.
            if (strobe && !load_ok) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        div_lat <= div_ratio;
                        div_cnt <= '0;
                        set_cnt <= '0;
                        win_cnt <= '0;
                        overrun <= 1'b0;
                        env_max <= 32'h8000_0000;
                        env_min <= 32'h7FFF_FFFF;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (DISCARD == 0) begin
                        state <= MEASURE;
                    end else if (fir_out_tvalid) begin
                        if (set_cnt == SET_LAST) begin
                            state <= MEASURE;
                        end else begin
                            set_cnt <= set_cnt + 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    if (fir_out_tvalid) begin
                        if (new_max) env_max <= fir_out_tdata;
                        if (new_min) env_min <= fir_out_tdata;
                        if (win_cnt == WIN_LAST) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_demod_sched.sv
// ---------------------------------------------------------------------------
// Self-checking bench for am_demod_sched. A behavioural model computes the
// expected strobe times, rectified samples, overrun and window extremes from
// cycle arithmetic; expected FIR-input samples and done results go into
// queues that a separate monitor process drains against DUT outputs.
// ---------------------------------------------------------------------------
module tb_am_demod_sched;

    localparam int DIV_W   = 8;
    localparam int DISCARD = 2;
    localparam int WIN_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  div_ratio = 8'd0;
    logic [7:0]  sample_in = 8'd0;
    logic        fir_in_tready = 1'b0;
    logic        fir_out_tvalid = 1'b0;
    logic [31:0] fir_out_tdata = 32'd0;
    logic        fir_in_tvalid;
    logic [7:0]  fir_in_tdata;
    logic        busy;
    logic        done;
    logic [31:0] env_max;
    logic [31:0] env_min;
    logic        overrun;

    am_demod_sched #(
        .DIV_W  (DIV_W),
        .DISCARD(DISCARD),
        .WIN_LEN(WIN_LEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .div_ratio     (div_ratio),
        .sample_in     (sample_in),
        .fir_in_tvalid (fir_in_tvalid),
        .fir_in_tready (fir_in_tready),
        .fir_in_tdata  (fir_in_tdata),
        .fir_out_tvalid(fir_out_tvalid),
        .fir_out_tdata (fir_out_tdata),
        .busy          (busy),
        .done          (done),
        .env_max       (env_max),
        .env_min       (env_min),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int mx;
        int mn;
        int at;
    } done_t;

    int    exp_data[$];
    done_t exp_done[$];
    int    beat_q[$];

    // Model state
    bit m_run, m_fin, m_pend, m_ovr, m_fresh;
    int m_t0, m_div, m_beats, m_max, m_min;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(3))
            0:       return 32'($urandom);
            1:       return 32'($signed($urandom_range(1000)) - 500);
            2:       return 32'h8000_0000;
            default: return 32'h7FFF_FFFF;
        endcase
    endfunction

    // One clock cycle: drive inputs, compare registered outputs against the
    // model, then advance the model over the coming rising edge.
    task automatic tick(input logic st, input logic [7:0] dv, input logic [7:0] smp,
                        input logic rdy, input logic ov, input logic [31:0] od);
        bit acc, strobe;
        int s, d;
        @(negedge clk);
        start = st; div_ratio = dv; sample_in = smp;
        fir_in_tready = rdy; fir_out_tvalid = ov; fir_out_tdata = od;

        check("busy", 32'(busy), 32'(m_run));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("fir_in_tvalid", 32'(fir_in_tvalid), 32'(m_pend));
        if (m_fresh) begin
            check("env_max_init", env_max, 32'h8000_0000);
            check("env_min_init", env_min, 32'h7FFF_FFFF);
        end
        m_fresh = 0;

        acc   = st && !m_run && !m_fin;
        m_fin = 0;

        strobe = m_run && (((cyc - m_t0) % (m_div + 1)) == 0);
        if (strobe) begin
            if (!m_pend || rdy) begin
                s = int'($signed(smp));
                exp_data.push_back(s < 0 ? 0 : s);
                m_pend = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_pend && rdy) begin
            m_pend = 0;
        end

        if (m_run && ov) begin
            m_beats++;
            if (m_beats > DISCARD) begin
                d = int'($signed(od));
                if (d > m_max) m_max = d;
                if (d < m_min) m_min = d;
            end
            if (m_beats == DISCARD + WIN_LEN) begin
                exp_done.push_back('{mx: m_max, mn: m_min, at: cyc + 1});
                m_run = 0;
                m_fin = 1;
            end
        end

        if (acc) begin
            m_run   = 1;
            m_t0    = cyc;
            m_div   = int'(dv);
            m_ovr   = 0;
            m_beats = 0;
            m_max   = int'(32'h8000_0000);
            m_min   = int'(32'h7FFF_FFFF);
            m_fresh = 1;
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_fin = 0; m_pend = 0; m_ovr = 0; m_fresh = 0;
        exp_data.delete();
        exp_done.delete();
        beat_q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        fir_out_tvalid = 1'b0;
        fir_in_tready = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tvalid", 32'(fir_in_tvalid), 32'd0);
        check("rst_tdata", 32'(fir_in_tdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_env_max", env_max, 32'd0);
        check("rst_env_min", env_min, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 not ready for the first 4 busy
    // clocks. smp_mode: 0 random, 1 +100 early then -50.
    task automatic run(input int div, input int rdy_mode, input int p_ov,
                       input int smp_mode, input int abort_beat);
        int guard, k;
        logic rdy, ov;
        logic [7:0] smp;
        logic [31:0] od;
        tick(1'b1, 8'(div), 8'($urandom), 1'b1, 1'b0, 32'd0);
        guard = 0;
        while (m_run && guard < 3000) begin
            guard++;
            k   = cyc + 1 - m_t0;
            rdy = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 2) ? (k > 4) : ($urandom_range(99) < 60);
            smp = (smp_mode == 1) ? ((k < 8) ? 8'd100 : 8'hCE) : 8'($urandom);
            ov  = ($urandom_range(99) < p_ov);
            if (ov && beat_q.size() > 0) od = 32'(beat_q.pop_front());
            else                         od = rnd_data();
            // Random start attempts and div_ratio changes while busy must
            // have no effect.
            tick($urandom_range(99) < 15, 8'($urandom), smp, rdy, ov, od);
            if (abort_beat > 0 && m_run && m_beats >= abort_beat) begin
                pulse_reset();
                return;
            end
        end
        if (m_run) check("run_timeout", 32'd1, 32'd0);
        // FINISH cycle: start and FIR beat here are both ignored.
        tick(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1, rnd_data());
        repeat (4) tick(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'($urandom), rnd_data());
    endtask

    // Monitor: scoreboard comparisons whenever the DUT presents output.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (fir_in_tvalid) begin
                    if (exp_data.size() == 0) begin
                        check("fir_in_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("fir_in_tdata", 32'(fir_in_tdata), 32'(exp_data[0]));
                        if (fir_in_tready) void'(exp_data.pop_front());
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        d = exp_done.pop_front();
                        check("done_cycle", 32'(cyc), 32'(d.at));
                        check("env_max", env_max, 32'(d.mx));
                        check("env_min", env_min, 32'(d.mn));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #1 reset = 1'b1;
        #1;
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_tvalid", 32'(fir_in_tvalid), 32'd0);
        check("init_tdata", 32'(fir_in_tdata), 32'd0);
        check("init_overrun", 32'(overrun), 32'd0);
        check("init_env_max", env_max, 32'd0);
        check("init_env_min", env_min, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle: FIR beats are ignored, nothing moves.
        for (int i = 0; i < 10; i++)
            tick(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'(i % 2), rnd_data());
        check("idle_env_max", env_max, 32'd0);
        check("idle_env_min", env_min, 32'd0);

        // div_ratio=4, always ready, +100 then -50.
        run(4, 0, 30, 1, 0);

        // Settling beats 999, 999 discarded; window 10, -5, 300, 7.
        beat_q = '{999, 999, 10, -5, 300, 7};
        run(1, 0, 50, 0, 0);
        check("directed_env_max", env_max, 32'd300);
        check("directed_env_min", env_min, 32'hFFFF_FFFB);

        // div_ratio=0 with tready low for the first clocks: overrun.
        run(0, 2, 30, 0, 0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Next accepted start clears overrun (model expects 0 after start).
        run(3, 0, 40, 0, 0);

        // Reset in the middle of the measure window, then a clean run.
        run(2, 1, 50, 0, DISCARD + 2);
        run(2, 1, 50, 0, 0);

        // Randomized runs.
        for (int r = 0; r < 12; r++)
            run($urandom_range(7), 1, $urandom_range(20, 80), 0, 0);

        check("data_queue_empty", 32'(exp_data.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
